// File: rtl/melody_sequencer.sv
// Autonomous 8-step tune player driving one-hot a/g/f/c note selects.
// Live keys override the selects and pause a playing song until released.
module melody_sequencer #(
   parameter int INPUT      = 48000000,
   parameter int BEAT_HZ    = 4,
   parameter int BEAT_DIV   = INPUT / BEAT_HZ,
   parameter int GAP_CYCLES = INPUT / 100,
   parameter int CW         = $clog2(4*BEAT_DIV+1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       play,
   input  logic       stop,
   input  logic       loop,
   input  logic       key_a,
   input  logic       key_g,
   input  logic       key_f,
   input  logic       key_c,
   output logic       a,
   output logic       g,
   output logic       f,
   output logic       c,
   output logic       sound_en,
   output logic       busy,
   output logic [2:0] step
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NOTE = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   // Terminal counts are last-cycle values: a phase of N cycles counts 0..N-1.
   localparam logic [CW-1:0] TERM_B1  = CW'(BEAT_DIV - 1);
   localparam logic [CW-1:0] TERM_B2  = CW'(2*BEAT_DIV - 1);
   localparam logic [CW-1:0] TERM_B3  = CW'(3*BEAT_DIV - 1);
   localparam logic [CW-1:0] TERM_B4  = CW'(4*BEAT_DIV - 1);
   localparam logic [CW-1:0] TERM_GAP = CW'(GAP_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [2:0]    step_q, step_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    sel_q, sel_d;   // {a, g, f, c}
   logic          snd_q, snd_d;
   logic          busy_q, busy_d;
   logic [4:0]    rom_cur, rom_nxt;
   logic [CW-1:0] note_term;
   logic          key_any;

   function automatic logic [4:0] song_rom(input logic [2:0] idx);
      logic [4:0] r;
      case (idx)
         3'd0:    r = {3'd1, 2'd1};
         3'd1:    r = {3'd2, 2'd1};
         3'd2:    r = {3'd3, 2'd1};
         3'd3:    r = {3'd4, 2'd2};
         3'd4:    r = {3'd0, 2'd1};
         3'd5:    r = {3'd4, 2'd1};
         3'd6:    r = {3'd3, 2'd1};
         default: r = {3'd1, 2'd2};
      endcase
      return r;
   endfunction

   assign key_any = key_a | key_g | key_f | key_c;
   assign rom_cur = song_rom(step_q);
   assign rom_nxt = song_rom(step_d);

   always_comb begin
      case (rom_cur[1:0])
         2'd1:    note_term = TERM_B1;
         2'd2:    note_term = TERM_B2;
         2'd3:    note_term = TERM_B3;
         default: note_term = TERM_B4;
      endcase
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      if (stop) begin
         state_d = S_IDLE;
         step_d  = 3'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (play) begin
                  state_d = S_NOTE;
                  step_d  = 3'd0;
                  cnt_d   = '0;
               end
            end
            S_NOTE: begin
               if (!key_any) begin
                  if (cnt_q == note_term) begin
                     cnt_d   = '0;
                     state_d = S_GAP;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            S_GAP: begin
               if (!key_any) begin
                  if (cnt_q == TERM_GAP) begin
                     cnt_d = '0;
                     if (step_q != 3'd7) begin
                        step_d  = step_q + 3'd1;
                        state_d = S_NOTE;
                     end else if (loop) begin
                        step_d  = 3'd0;
                        state_d = S_NOTE;
                     end else begin
                        state_d = S_IDLE;
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               step_d  = 3'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with it once registered.
   always_comb begin
      sel_d = 4'b0000;
      if (key_a)      sel_d = 4'b1000;
      else if (key_g) sel_d = 4'b0100;
      else if (key_f) sel_d = 4'b0010;
      else if (key_c) sel_d = 4'b0001;
      else if (state_d == S_NOTE) begin
         case (rom_nxt[4:2])
            3'd1:    sel_d = 4'b0001;
            3'd2:    sel_d = 4'b0010;
            3'd3:    sel_d = 4'b0100;
            3'd4:    sel_d = 4'b1000;
            default: sel_d = 4'b0000;
         endcase
      end
      snd_d  = |sel_d;
      busy_d = (state_d == S_NOTE) || (state_d == S_GAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= 3'd0;
         cnt_q   <= '0;
         sel_q   <= 4'b0000;
         snd_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         snd_q   <= snd_d;
         busy_q  <= busy_d;
      end
   end

   assign {a, g, f, c} = sel_q;
   assign sound_en     = snd_q;
   assign busy         = busy_q;
   assign step         = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: idle vector table plus a
// scoreboard queue of per-cycle expected outputs for song playback cases.
module tb_melody_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       play = 1'b0, stop = 1'b0, loop = 1'b0;
   logic       key_a = 1'b0, key_g = 1'b0, key_f = 1'b0, key_c = 1'b0;
   logic       a, g, f, c, sound_en, busy;
   logic [2:0] step;

   int n_chk  = 0;
   int n_fail = 0;

   melody_sequencer #(.BEAT_DIV(10), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .play(play), .stop(stop), .loop(loop),
      .key_a(key_a), .key_g(key_g), .key_f(key_f), .key_c(key_c),
      .a(a), .g(g), .f(f), .c(c), .sound_en(sound_en), .busy(busy), .step(step)
   );

   always #5 clk = ~clk;

   wire [8:0] outv = {a, g, f, c, sound_en, busy, step};

   typedef struct {
      logic       play, stop;
      logic [3:0] keys;   // {a, g, f, c}
      logic [8:0] exp;    // {a, g, f, c, sound_en, busy, step}
   } vec_t;

   vec_t       vecs[8];
   logic [8:0] song[$];
   logic [8:0] exp_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] sel_of(input int note);
      case (note)
         1:       return 4'b0001;
         2:       return 4'b0010;
         3:       return 4'b0100;
         4:       return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic build_song();
      int nt[8] = '{1, 2, 3, 4, 0, 4, 3, 1};
      int bt[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
      logic [3:0] s;
      for (int i = 0; i < 8; i++) begin
         s = sel_of(nt[i]);
         for (int k = 0; k < bt[i]*10; k++) song.push_back({s, |s, 1'b1, 3'(i)});
         for (int k = 0; k < 2; k++) song.push_back({4'b0000, 1'b0, 1'b1, 3'(i)});
      end
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) exp_q.push_back(song[i]);
   endtask

   // Compare queued expectations one per cycle; returns on the last compared cycle.
   task automatic drain(input string nm);
      logic [8:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(nm, outv, e);
         if (exp_q.size() > 0) tick();
      end
   endtask

   task automatic start_song();
      play = 1'b1;
      tick();
      play = 1'b0;
   endtask

   task automatic abort();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("abort_idle", outv, 9'b0);
   endtask

   initial begin
      vecs[0] = '{play: 1'b0, stop: 1'b0, keys: 4'b0000, exp: 9'b0000_0_0_000};
      vecs[1] = '{play: 1'b1, stop: 1'b1, keys: 4'b0000, exp: 9'b0000_0_0_000};
      vecs[2] = '{play: 1'b0, stop: 1'b0, keys: 4'b1001, exp: 9'b1000_1_0_000};
      vecs[3] = '{play: 1'b0, stop: 1'b0, keys: 4'b0110, exp: 9'b0100_1_0_000};
      vecs[4] = '{play: 1'b0, stop: 1'b0, keys: 4'b0011, exp: 9'b0010_1_0_000};
      vecs[5] = '{play: 1'b0, stop: 1'b0, keys: 4'b0001, exp: 9'b0001_1_0_000};
      vecs[6] = '{play: 1'b0, stop: 1'b1, keys: 4'b0100, exp: 9'b0100_1_0_000};
      vecs[7] = '{play: 1'b0, stop: 1'b0, keys: 4'b0000, exp: 9'b0000_0_0_000};
      build_song();

      #2;
      chk("reset_state", outv, 9'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_reset_idle", outv, 9'b0);

      // Idle behaviour: play+stop collision and key overrides
      for (int i = 0; i < 8; i++) begin
         play = vecs[i].play;
         stop = vecs[i].stop;
         {key_a, key_g, key_f, key_c} = vecs[i].keys;
         tick();
         chk($sformatf("vec%0d", i), outv, vecs[i].exp);
      end
      play = 1'b0; stop = 1'b0;
      {key_a, key_g, key_f, key_c} = 4'b0000;

      // Full non-looping song: 116 busy cycles then idle
      loop = 1'b0;
      start_song();
      push_range(0, 115);
      drain("song");
      play = 1'b1;       // ignored while busy
      tick();
      play = 1'b0;
      chk("song_end_idle", {outv[8:3], 3'b000}, 9'b0);

      // Looping: wraps to step 0 without dropping busy
      loop = 1'b1;
      start_song();
      push_range(0, 115);
      push_range(0, 2);
      drain("loop");
      loop = 1'b0;
      abort();

      // Stop at cycle 5 of step 3, then restart
      start_song();
      push_range(0, 41);
      drain("pre_stop");
      abort();
      start_song();
      chk("restart_c", outv, song[0]);
      abort();

      // key_g pause during step 0
      start_song();
      push_range(0, 2);
      drain("pre_key");
      key_g = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) exp_q.push_back({4'b0100, 1'b1, 1'b1, 3'd0});
      drain("key_g_hold");
      key_g = 1'b0;
      tick();
      push_range(3, 14);
      drain("key_resume");
      abort();

      // Asynchronous reset mid-note at step 3
      start_song();
      push_range(0, 40);
      drain("pre_reset");
      rst = 1'b1;
      #1;
      chk("async_reset", outv, 9'b0);
      tick();
      rst = 1'b0;
      tick();
      chk("reset_idle_1", outv, 9'b0);
      tick();
      chk("reset_idle_2", outv, 9'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
